// File: rtl/mprj_io_filt.sv
// mprj_io_filt: two-area user pad ring with per-pad input synchroniser, glitch filter and edge detect.
// Define MPRJ_IO_IRQ_EN to add per-pad interrupt latching; otherwise irq_pend/irq are tied low.

module fpga_gpio (
    inout  wire  pad,
    input  logic chip_o,
    input  logic chip_oe,   // active-low output enable, driven straight from oeb
    input  logic chip_ie,
    output logic chip_i
);
    assign pad    = chip_oe ? 1'bz : chip_o;
    assign chip_i = chip_ie & pad;
endmodule

module mprj_io_filt #(
    parameter int AREA1PADS   = 19,
    parameter int TOTAL_PADS  = 38,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    inout  wire  [TOTAL_PADS-1:0] io,
    input  logic [TOTAL_PADS-1:0] io_out,
    input  logic [TOTAL_PADS-1:0] oeb,
    input  logic [TOTAL_PADS-1:0] inp_dis,
    input  logic [FILT_W-1:0]     filt_len,
    input  logic [TOTAL_PADS-1:0] rise_en,
    input  logic [TOTAL_PADS-1:0] fall_en,
    input  logic [TOTAL_PADS-1:0] irq_clr,
    output logic [TOTAL_PADS-1:0] io_in,
    output logic [TOTAL_PADS-1:0] edge_rise,
    output logic [TOTAL_PADS-1:0] edge_fall,
    output logic [TOTAL_PADS-1:0] irq_pend,
    output logic                  irq
);
    logic [TOTAL_PADS-1:0] chip_ie;
    logic [TOTAL_PADS-1:0] chip_i;
    logic [TOTAL_PADS-1:0] sync_q [SYNC_STAGES];
    logic [TOTAL_PADS-1:0] sync_out;
    logic [TOTAL_PADS-1:0] q;
    logic [TOTAL_PADS-1:0] q_prev;
    logic [FILT_W-1:0]     cnt [TOTAL_PADS];

    assign chip_ie = ~inp_dis;

    for (genvar g = 0; g < AREA1PADS; g++) begin : g_area1
        fpga_gpio u_pad (
            .pad     (io[g]),
            .chip_o  (io_out[g]),
            .chip_oe (oeb[g]),
            .chip_ie (chip_ie[g]),
            .chip_i  (chip_i[g])
        );
    end

    for (genvar g = AREA1PADS; g < TOTAL_PADS; g++) begin : g_area2
        fpga_gpio u_pad (
            .pad     (io[g]),
            .chip_o  (io_out[g]),
            .chip_oe (oeb[g]),
            .chip_ie (chip_ie[g]),
            .chip_i  (chip_i[g])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= chip_i & ~inp_dis;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // NOTE: the counter array is reset explicitly so a reset discards any partially filtered pulse.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            q <= '0;
            for (int i = 0; i < TOTAL_PADS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < TOTAL_PADS; i++) begin
                if (sync_out[i] == q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= filt_len) begin
                    q[i]   <= sync_out[i];
                    cnt[i] <= '0;
                end else if (cnt[i] != {FILT_W{1'b1}}) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign io_in = q;

    // Edges are reported one cycle after the filtered value moves.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            q_prev    <= '0;
            edge_rise <= '0;
            edge_fall <= '0;
        end else begin
            q_prev    <= q;
            edge_rise <= q & ~q_prev;
            edge_fall <= ~q & q_prev;
        end
    end

`ifdef MPRJ_IO_IRQ_EN
    // Set has priority over a simultaneous clear so no edge is ever lost.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_pend <= '0;
            irq      <= 1'b0;
        end else begin
            irq_pend <= (irq_pend & ~irq_clr) | (edge_rise & rise_en) | (edge_fall & fall_en);
            irq      <= |irq_pend;
        end
    end
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{rise_en, fall_en, irq_clr};
    assign irq_pend = '0;
    assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_mprj_io_filt.sv
// Self-checking bench for mprj_io_filt: directed scenarios plus randomized traffic against a reference model.
// Builds with or without MPRJ_IO_IRQ_EN; expected interrupt behaviour follows the macro.

module tb_mprj_io_filt;
    localparam int N    = 38;
    localparam int SYNC = 2;
    localparam int FW   = 4;
`ifdef MPRJ_IO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  io_out, oeb, inp_dis, rise_en, fall_en, irq_clr, tb_val;
    logic [FW-1:0] filt_len;
    wire  [N-1:0]  io;
    logic [N-1:0]  io_in, edge_rise, edge_fall, irq_pend;
    logic          irq;

    always #5 clk = ~clk;

    // The bench drives a pad only while the DUT's output driver is off.
    for (genvar g = 0; g < N; g++) begin : g_drv
        assign io[g] = oeb[g] ? tb_val[g] : 1'bz;
    end

    mprj_io_filt #(
        .AREA1PADS   (19),
        .TOTAL_PADS  (N),
        .SYNC_STAGES (SYNC),
        .FILT_W      (FW)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .io        (io),
        .io_out    (io_out),
        .oeb       (oeb),
        .inp_dis   (inp_dis),
        .filt_len  (filt_len),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .irq_clr   (irq_clr),
        .io_in     (io_in),
        .edge_rise (edge_rise),
        .edge_fall (edge_fall),
        .irq_pend  (irq_pend),
        .irq       (irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    // Reference model: a delay line for the synchroniser, a run length of disagreeing
    // cycles for the filter, and one-cycle-late edge reporting.
    logic [N-1:0] m_hist[$];
    logic [N-1:0] m_q, m_up, m_dn, m_rise, m_fall, m_pend;
    logic         m_irq;
    int           m_run[N];

    task automatic model_step(input logic r, input logic [N-1:0] smp, input int fl,
                              input logic [N-1:0] re, input logic [N-1:0] fe,
                              input logic [N-1:0] clr);
        logic [N-1:0] s, nq;
        if (r) begin
            m_q = '0; m_up = '0; m_dn = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
            foreach (m_run[i]) m_run[i] = 0;
            m_hist.delete();
            repeat (SYNC) m_hist.push_back('0);
            return;
        end
        s = m_hist.pop_front();
        m_hist.push_back(smp);
        nq = m_q;
        for (int i = 0; i < N; i++) begin
            if (s[i] == m_q[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] > fl) begin
                    nq[i]    = s[i];
                    m_run[i] = 0;
                end
            end
        end
        if (IRQ_ON) begin
            m_irq  = |m_pend;
            m_pend = (m_pend & ~clr) | (m_rise & re) | (m_fall & fe);
        end
        m_rise = m_up;
        m_fall = m_dn;
        m_up   = nq & ~m_q;
        m_dn   = m_q & ~nq;
        m_q    = nq;
    endtask

    task automatic tick();
        logic         r;
        logic [N-1:0] smp, re, fe, clr;
        int           fl;
        r   = rst;
        smp = ((oeb & tb_val) | (~oeb & io_out)) & ~inp_dis;
        fl  = int'(filt_len);
        re  = rise_en;
        fe  = fall_en;
        clr = irq_clr;
        @(posedge clk);
        model_step(r, smp, fl, re, fe, clr);
        #1;
        check("io_in", io_in, m_q);
        check("edge_rise", edge_rise, m_rise);
        check("edge_fall", edge_fall, m_fall);
        check("irq_pend", irq_pend, m_pend);
        check("irq", irq, m_irq);
    endtask

    function automatic logic [N-1:0] rnd();
        logic [63:0] r64;
        r64 = {$urandom(), $urandom()};
        return r64[N-1:0];
    endfunction

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt_a, cnt_b, lat;
        logic [N-1:0] pat;

        rst = 1'b1; io_out = '0; oeb = '1; inp_dis = '0; rise_en = '0; fall_en = '0;
        irq_clr = '0; tb_val = '0; filt_len = 4'd3;

        // Reset values, then pad 0 held high through release.
        repeat (3) tick();
        check("rst_io_in", io_in, 0);
        check("rst_edges", {edge_rise, edge_fall}, 0);
        check("rst_pend", irq_pend, 0);
        check("rst_irq", irq, 0);
        tb_val[0] = 1'b1;
        tick();
        rst   = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 5) check("rst_lat_c5", io_in[0], 0);
            if (k == 6) check("rst_lat_c6", io_in[0], 1);
            if (edge_rise[0]) cnt_a++;
            if (edge_fall != '0) cnt_b++;
        end
        check("rst_one_rise", cnt_a, 1);
        check("rst_no_fall", cnt_b, 0);

        // Glitch rejection: a 3-cycle pulse vanishes, a 4-cycle pulse passes for 4 cycles.
        for (int w = 3; w <= 4; w++) begin
            cnt_a = 0;
            cnt_b = 0;
            tb_val[5] = 1'b1;
            for (int k = 0; k < 16; k++) begin
                if (k == w) tb_val[5] = 1'b0;
                tick();
                if (io_in[5]) cnt_a++;
                if (edge_rise[5] | edge_fall[5]) cnt_b++;
            end
            check(w == 3 ? "glitch3_high" : "pulse4_high", cnt_a, w == 3 ? 0 : 4);
            check(w == 3 ? "glitch3_edges" : "pulse4_edges", cnt_b, w == 3 ? 0 : 2);
        end

        // Input disable forces the synchroniser input low.
        inp_dis[7] = 1'b1;
        tb_val[7]  = 1'b1;
        repeat (10) tick();
        check("inp_dis_low", io_in[7], 0);
        inp_dis[7] = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if (io_in[7]) lat = k;
        end
        check("inp_dis_latency", lat, SYNC + 3 + 1);

        // Interrupt latching, clear, and set-beats-clear.
        rise_en[2] = 1'b1;
        tb_val[2]  = 1'b1;
        cnt_a = 0;
        for (int k = 0; k < 20 && cnt_a == 0; k++) begin
            tick();
            if (edge_rise[2]) cnt_a = 1;
        end
        check("irq_rise_seen", cnt_a, 1);
        tick();
        check("irq_pend_set", irq_pend[2], IRQ_ON);
        check("irq_not_yet", irq, 0);
        tick();
        check("irq_follows", irq, IRQ_ON);
        irq_clr[2] = 1'b1;
        tick();
        irq_clr[2] = 1'b0;
        check("irq_cleared", irq_pend[2], 0);
        tb_val[2] = 1'b0;
        repeat (10) tick();
        tb_val[2] = 1'b1;
        cnt_a = 0;
        for (int k = 0; k < 20 && cnt_a == 0; k++) begin
            tick();
            if (edge_rise[2]) cnt_a = 1;
        end
        check("irq_rise2_seen", cnt_a, 1);
        irq_clr[2] = 1'b1;
        tick();
        irq_clr[2] = 1'b0;
        check("irq_set_wins", irq_pend[2], IRQ_ON);
        rise_en = '0;
        irq_clr = '1;
        tick();
        irq_clr = '0;

        // Loopback through both areas with the DUT driving every pad.
        for (int i = 0; i < N; i++) pat[i] = (i % 2 == 0);
        io_out = pat;
        oeb    = '0;
        tb_val = '0;
        lat    = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if (k == 1) begin
                check("pad0_level", io[0], 1);
                check("pad37_level", io[N-1], 0);
            end
            if (io_in == pat) lat = k;
        end
        check("loopback_latency", lat, SYNC + 3 + 1);

        // Randomized traffic, including mid-count filter-length changes and occasional reset.
        oeb      = rnd();
        io_out   = rnd();
        tb_val   = rnd();
        filt_len = 4'($urandom_range(0, 4));
        for (int k = 0; k < 3000; k++) begin
            tb_val ^= rnd() & rnd() & rnd();
            io_out ^= rnd() & rnd() & rnd() & rnd();
            irq_clr = rnd() & rnd() & rnd();
            inp_dis = ($urandom_range(0, 99) < 5) ? (rnd() & rnd()) : '0;
            rst     = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0) filt_len = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 99) == 0) begin
                oeb     = rnd();
                rise_en = rnd();
                fall_en = rnd();
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mprj_io_filt.md
MPRJ_IO_FILT -- requirements
Module: mprj_io_filt

Interface
REQ-001 SHALL have parameter AREA1PADS, default 19: number of pads in user area 1, i.e. pads [AREA1PADS-1:0].
REQ-002 SHALL have parameter TOTAL_PADS, default 38: total pad count; area 2 is pads [TOTAL_PADS-1:AREA1PADS].
REQ-003 SHALL have parameter SYNC_STAGES, default 2, legal range 2..4: number of input synchroniser flops per pad.
REQ-004 SHALL have parameter FILT_W, default 4: bit width of the glitch-filter counter and of filt_len.
REQ-005 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port io, inout, TOTAL_PADS bits: pad pins.
REQ-008 SHALL have port io_out, input, TOTAL_PADS bits: output data to the pads.
REQ-009 SHALL have port oeb, input, TOTAL_PADS bits: output enable per pad, passed to pad chip_oe.
REQ-010 SHALL have port inp_dis, input, TOTAL_PADS bits: input disable per pad; pad chip_ie = ~inp_dis.
REQ-011 SHALL have port filt_len, input, FILT_W bits: glitch-filter length in cycles, shared by all pads.
REQ-012 SHALL have port rise_en, input, TOTAL_PADS bits: per-pad rising-edge interrupt enable.
REQ-013 SHALL have port fall_en, input, TOTAL_PADS bits: per-pad falling-edge interrupt enable.
REQ-014 SHALL have port irq_clr, input, TOTAL_PADS bits: per-pad pending-bit clear, one-cycle pulse.
REQ-015 SHALL have port io_in, output, TOTAL_PADS bits: synchronised, filtered input value.
REQ-016 SHALL have port edge_rise, output, TOTAL_PADS bits: one-cycle pulse on a 0->1 transition of io_in.
REQ-017 SHALL have port edge_fall, output, TOTAL_PADS bits: one-cycle pulse on a 1->0 transition of io_in.
REQ-018 SHALL have port irq_pend, output, TOTAL_PADS bits: latched pending interrupts.
REQ-019 SHALL have port irq, output, 1 bit: OR of irq_pend.

Function
REQ-020 SHALL instantiate one fpga_gpio per pad, in two arrays (area 1 and area 2); io_out and oeb SHALL go to the pad combinationally, with no registering.
REQ-021 SHALL pass the pad chip_i through SYNC_STAGES flops; when inp_dis[i]=1 the synchroniser input SHALL be forced to 0.
REQ-022 Per pad, the filter SHALL hold a stable value q[i] and a counter cnt[i] of FILT_W bits:
  - synchroniser output == q: cnt <= 0.
  - synchroniser output != q and cnt >= filt_len: q <= synchroniser output, cnt <= 0.
  - otherwise: cnt <= cnt+1, saturating at all-ones.
REQ-023 io_in SHALL equal q; with a steady input, latency from pad change to io_in change SHALL be SYNC_STAGES+filt_len+1 cycles.
REQ-024 filt_len=0 SHALL give pass-through: pulses of 1 cycle or longer propagate.
REQ-025 A pulse shorter than filt_len+1 cycles (as seen after the synchroniser) SHALL NOT change io_in.
REQ-026 A change of filt_len mid-count SHALL take effect on the next compare, with no counter reset.
REQ-027 edge_rise/edge_fall SHALL be registered: asserted for exactly one cycle, in the cycle after q changes.

Reset
REQ-028 While wb_rst_i=1 at a clock edge, all of the following SHALL be cleared to 0: synchroniser flops, q, cnt, io_in, edge_rise, edge_fall, irq_pend and irq.
REQ-029 Reset asserted mid-filter SHALL discard partial counts; after release, a pad held high SHALL reach io_in after SYNC_STAGES+filt_len+1 cycles.
REQ-030 The first cycles after reset SHALL NOT produce spurious edges: a pad held low at reset release SHALL never pulse edge_fall.

Configuration
REQ-031 The macro MPRJ_IO_IRQ_EN SHALL select interrupt latching.
REQ-032 With MPRJ_IO_IRQ_EN defined:
  - irq_pend[i] SHALL be set by (edge_rise[i]&rise_en[i]) | (edge_fall[i]&fall_en[i]).
  - irq_pend[i] SHALL be cleared by irq_clr[i]; set SHALL win over a simultaneous clear.
  - irq SHALL be registered, one cycle after irq_pend.
REQ-033 Without MPRJ_IO_IRQ_EN, irq_pend and irq SHALL be tied to 0, and rise_en, fall_en and irq_clr SHALL be ignored; edge outputs SHALL remain.

Verification
REQ-034 Reset: filt_len=3, pad 0 driven 1 continuously, wb_rst_i released at cycle 0 -> io_in[0]=1 from cycle 6 (SYNC_STAGES=2), with exactly one edge_rise[0] pulse.
REQ-035 Glitch: filt_len=3, 3-cycle high pulse on pad 5 -> io_in[5] stays 0, no edges; a 4-cycle pulse -> io_in[5] high for 4 cycles.
REQ-036 Input disable: inp_dis[7]=1 with pad 7 driven 1 -> io_in[7]=0; release inp_dis -> io_in[7]=1 after SYNC_STAGES+filt_len+1 cycles.
REQ-037 IRQ (macro on): rise_en[2]=1, pad 2 rises -> irq_pend[2]=1, then irq=1 one cycle later; irq_clr[2] pulsed in the same cycle as a new edge -> irq_pend[2] stays 1.
REQ-038 IRQ (macro off): same stimulus as REQ-037 -> irq=0 and irq_pend=0 throughout; edge_rise[2] still pulses.
REQ-039 Areas: AREA1PADS=19, TOTAL_PADS=38, drive io_out=alternating 1/0 with oeb=0 on all pads -> pads 0 and 37 show the expected levels, and io_in reflects them after loopback.
